red_pitaya_guitar_drive_ctrl: RTL and testbench
===============================================

# red_pitaya_guitar_drive_ctrl

Drive-parameter sequencer for the guitar amplifier stage. It accepts drive settings from the housekeeping register interface and produces the signed 16-bit drive value consumed by the amplifier multiplier. Changes are ramped one step per audio sample to avoid zipper noise, and a mute request ramps the drive to zero and holds it there. The block sits between the register bank and the amplifier's drive input, in the ADC clock domain.

## Interface
- `STEP_W`, default 15: width of the unsigned ramp step.
- `clk_i`  in  1  ADC clock; all logic is on the rising edge.
- `rst_i`  in  1  Asynchronous, active-high reset.
- `smp_stb_i`  in  1  One-cycle pulse per audio sample; ramp updates occur only on this pulse.
- `cfg_we_i`  in  1  One-cycle write strobe from the register bank.
- `cfg_drive_i`  in  16  Signed target drive. Sampled when `cfg_we_i`=1.
- `cfg_step_i`  in  STEP_W  Unsigned step per sample. Sampled when `cfg_we_i`=1. A value of 0 means jump immediately.
- `cfg_ack_o`  out  1  One-cycle pulse, asserted in the cycle after the accepted `cfg_we_i`.
- `mute_i`  in  1  Level signal. While 1, the effective target is 0.
- `drive_o`  out  16  Registered signed drive value sent to the amplifier.
- `busy_o`  out  1  1 while the state is RAMP.
- `done_o`  out  1  One-cycle pulse when a ramp lands exactly on the effective target.
- `state_o`  out  2  Current FSM state: IDLE=0, RAMP=1, MUTED=2.

## Operation
- Registers:
  - `target` (16b signed) and `step` (STEP_W unsigned) are loaded on `cfg_we_i`.
  - `cfg_we_i` is accepted in every state; there is no back-pressure.
- Effective target: `eff = mute_i ? 0 : target`.
- Ramp arithmetic, evaluated when `smp_stb_i`=1 and `drive_o != eff`:
  - `diff = eff - drive_o`, computed at 17 bits signed.
  - If `step`=0 or `|diff| <= step`: `drive_o <= eff`.
  - Otherwise, if `diff` > 0: `drive_o <= drive_o + step`.
  - Otherwise: `drive_o <= drive_o - step`.
  - Both additions are done at 17 bits. Because of the `|diff|` check, the result always lies between `drive_o` and `eff`, so no overflow or saturation is possible.
- FSM, with next state decided each cycle from registered values:
  - IDLE: `drive_o == eff` and `mute_i`=0.
    - Go to RAMP when `drive_o != eff`, i.e. after a new target is loaded or `mute_i` rises.
  - RAMP: `drive_o != eff`.
    - Go to IDLE when `drive_o == eff` and `mute_i`=0.
    - Go to MUTED when `drive_o == eff` (= 0) and `mute_i`=1.
  - MUTED: `mute_i`=1 and `drive_o`=0.
    - Go to RAMP when `mute_i` falls and `target != 0`.
    - Go to IDLE when `mute_i` falls and `target` = 0.
  - When `eff` already equals `drive_o`, IDLE and MUTED are entered directly without passing through RAMP.
- Retarget mid-ramp: the new target takes effect from the current `drive_o`. There is no restart and the step is not reset.
- Mute mid-ramp: the ramp heads toward 0 from the current value at the current `step`.
- Unmute mid-ramp-down: the ramp reverses toward `target` from the current value.
- `done_o`: pulses in the cycle where `drive_o` becomes equal to `eff` as the result of a strobe update.
  - It does not pulse for an immediate equality caused by a config write alone.

## Timing
- Reset values (asynchronous, take effect immediately):
  - `drive_o`=0, `target`=0, `step`=0.
  - `state_o`=IDLE.
  - `busy_o`=0, `done_o`=0, `cfg_ack_o`=0.
- Config write: `cfg_we_i` in cycle N → registers updated at edge N+1 → `cfg_ack_o`=1 during cycle N+1.
- Strobe latency: `smp_stb_i` in cycle N → new `drive_o` visible in cycle N+1.
- `state_o`, `busy_o` and `done_o` reflect the updated `drive_o` in cycle N+1. All three are registered, with no combinational path from inputs.
- Simultaneous `cfg_we_i` and `smp_stb_i` in the same cycle: the ramp step uses the old `target` and `step`. The new values apply from the next strobe.
- Simultaneous `mute_i` change and `smp_stb_i`: the step uses `eff` computed from `mute_i` in that same cycle.
- Strobes in IDLE or MUTED leave `drive_o` unchanged.
- Reset asserted mid-ramp: all outputs return to their reset values at once. After release, the block idles at drive 0.

## Test plan
- Reset, then write target 0x0400 with step 0x0100, then give 4 strobes:
  - `cfg_ack_o` pulses one cycle after the write.
  - `drive_o` reads 0x0100, 0x0200, 0x0300, 0x0400.
  - `done_o` pulses once, after the 4th strobe.
  - State goes RAMP → IDLE.
- Non-multiple step: target 0x0350 with step 0x0100, starting from drive 0:
  - `drive_o` reads 0x0100, 0x0200, 0x0300, 0x0350.
  - There is no overshoot.
- Negative extremes:
  - Target 0x8000 with step 0x7FFF, starting from 0x7FFF: `drive_o` reads 0x0000, then 0x8001, then 0x8000. There is no wrap.
  - Step 0 with target 0x1234: `drive_o` = 0x1234 after the first strobe.
- Mute during ramp:
  - At drive 0x0200 (target 0x0400, step 0x0100), raise `mute_i`.
  - `drive_o` reads 0x0100, then 0x0000; state becomes MUTED.
  - Drop `mute_i`: state becomes RAMP, and `drive_o` climbs back to 0x0400.
- Retarget plus collision:
  - At drive 0x0200, apply `cfg_we_i` with target 0x0000 in the same cycle as a strobe.
  - That strobe yields 0x0300 (old target); subsequent strobes yield 0x0200, 0x0100, 0x0000.
- Reset mid-ramp:
  - Assert `rst_i` asynchronously while at drive 0x0300.
  - `drive_o` = 0, `state_o` = IDLE, and all pulse outputs = 0 before the next clock edge.
  - After release, strobes leave `drive_o` at 0.

Source files
------------

// File: rtl/red_pitaya_guitar_drive_ctrl.sv
// Guitar drive sequencer: ramps the amplifier drive toward the (mute-gated) target once per sample strobe.
// Strobe-to-drive latency 1 cycle, config ack 1 cycle after write; writes are always accepted (no back-pressure).
module red_pitaya_guitar_drive_ctrl #(
  parameter int STEP_W = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              smp_stb_i,
  input  logic              cfg_we_i,
  input  logic [15:0]       cfg_drive_i,
  input  logic [STEP_W-1:0] cfg_step_i,
  output logic              cfg_ack_o,
  input  logic              mute_i,
  output logic [15:0]       drive_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    MUTED = 2'd2
  } state_t;

  state_t            state_q, state_nxt;
  logic [15:0]       drive_q, drive_nxt;
  logic [15:0]       target_q, target_nxt;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic              busy_q, done_q, ack_q;

  logic [15:0] eff, eff_nxt, step16;
  logic [16:0] diff, mag;
  logic        upd, done_nxt;

  // Ramp arithmetic works on sign-extended 17-bit values so the distance never overflows.
  always_comb begin
    eff    = mute_i ? 16'd0 : target_q;
    step16 = {{(16-STEP_W){1'b0}}, step_q};
    diff   = {eff[15], eff} - {drive_q[15], drive_q};
    mag    = diff[16] ? (17'd0 - diff) : diff;
    upd    = smp_stb_i && (drive_q != eff);

    drive_nxt = drive_q;
    if (upd) begin
      if ((step_q == '0) || (mag <= {1'b0, step16}))
        drive_nxt = eff;
      else if (!diff[16])
        drive_nxt = drive_q + step16;
      else
        drive_nxt = drive_q - step16;
    end

    // A write coinciding with a strobe only affects later strobes.
    target_nxt = cfg_we_i ? cfg_drive_i : target_q;
    step_nxt   = cfg_we_i ? cfg_step_i  : step_q;
    eff_nxt    = mute_i ? 16'd0 : target_nxt;
    done_nxt   = upd && (drive_nxt == eff);
  end

  // State is decided from the post-edge drive and target so it lines up with drive_o.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (drive_nxt != eff_nxt)
          state_nxt = RAMP;
        else if (mute_i)
          state_nxt = MUTED;
      end
      RAMP: begin
        if (drive_nxt == eff_nxt)
          state_nxt = mute_i ? MUTED : IDLE;
      end
      MUTED: begin
        if (!mute_i)
          state_nxt = (drive_nxt != eff_nxt) ? RAMP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      drive_q  <= '0;
      target_q <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      drive_q  <= drive_nxt;
      target_q <= target_nxt;
      step_q   <= step_nxt;
      busy_q   <= (state_nxt == RAMP);
      done_q   <= done_nxt;
      ack_q    <= cfg_we_i;
    end
  end

  assign drive_o   = drive_q;
  assign state_o   = state_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cfg_ack_o = ack_q;

endmodule

// File: tb/tb_red_pitaya_guitar_drive_ctrl.sv
// Directed bench for the guitar drive sequencer with hand-computed expectations.
module tb_red_pitaya_guitar_drive_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        smp_stb_i;
  logic        cfg_we_i;
  logic [15:0] cfg_drive_i;
  logic [14:0] cfg_step_i;
  logic        cfg_ack_o;
  logic        mute_i;
  logic [15:0] drive_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_MUTED = 2'd2;

  red_pitaya_guitar_drive_ctrl #(.STEP_W(15)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .smp_stb_i   (smp_stb_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_drive_i (cfg_drive_i),
    .cfg_step_i  (cfg_step_i),
    .cfg_ack_o   (cfg_ack_o),
    .mute_i      (mute_i),
    .drive_o     (drive_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .state_o     (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [15:0] d, input logic [14:0] s);
    cfg_we_i    = 1'b1;
    cfg_drive_i = d;
    cfg_step_i  = s;
    tick();
    cfg_we_i    = 1'b0;
  endtask

  task automatic strobe();
    smp_stb_i = 1'b1;
    tick();
    smp_stb_i = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_a [4];
    rst_i       = 1'b1;
    smp_stb_i   = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_drive_i = '0;
    cfg_step_i  = '0;
    mute_i      = 1'b0;
    #12;
    chk("rst_drive", drive_o, 0);
    chk("rst_state", state_o, S_IDLE);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ack", cfg_ack_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Basic ramp 0 -> 0x0400 in 0x0100 steps
    cfg(16'h0400, 15'h0100);
    chk("t1_ack", cfg_ack_o, 1);
    chk("t1_state_ramp", state_o, S_RAMP);
    chk("t1_busy", busy_o, 1);
    chk("t1_no_done_on_write", done_o, 0);
    for (int i = 0; i < 4; i++) begin
      strobe();
      chk("t1_drive", drive_o, 32'((i + 1) * 16'h0100));
      chk("t1_done", done_o, (i == 3) ? 1 : 0);
      chk("t1_state", state_o, (i == 3) ? S_IDLE : S_RAMP);
    end
    chk("t1_ack_gone", cfg_ack_o, 0);
    tick();
    chk("t1_done_one_cycle", done_o, 0);
    strobe();
    chk("t1_idle_strobe_hold", drive_o, 16'h0400);

    // Non-multiple step, no overshoot
    cfg(16'h0000, 15'h0000);
    strobe();
    chk("t2_jump_zero", drive_o, 0);
    cfg(16'h0350, 15'h0100);
    exp_a = '{16'h0100, 16'h0200, 16'h0300, 16'h0350};
    for (int i = 0; i < 4; i++) begin
      strobe();
      chk("t2_drive", drive_o, exp_a[i]);
    end
    strobe();
    chk("t2_no_overshoot", drive_o, 16'h0350);

    // Negative extremes
    cfg(16'h7FFF, 15'h0000);
    strobe();
    chk("t3_jump_max", drive_o, 16'h7FFF);
    cfg(16'h8000, 15'h7FFF);
    exp_a = '{16'h0000, 16'h8001, 16'h8000, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      strobe();
      chk("t3_drive", drive_o, exp_a[i]);
      chk("t3_done", done_o, (i == 2) ? 1 : 0);
    end
    cfg(16'h1234, 15'h0000);
    strobe();
    chk("t3_step0", drive_o, 16'h1234);
    chk("t3_step0_done", done_o, 1);

    // Mute during ramp
    cfg(16'h0200, 15'h0000);
    strobe();
    chk("t4_pre", drive_o, 16'h0200);
    cfg(16'h0400, 15'h0100);
    mute_i = 1'b1;
    strobe();
    chk("t4_mute1", drive_o, 16'h0100);
    chk("t4_mute1_state", state_o, S_RAMP);
    strobe();
    chk("t4_mute2", drive_o, 16'h0000);
    chk("t4_muted_state", state_o, S_MUTED);
    chk("t4_muted_busy", busy_o, 0);
    chk("t4_mute_done", done_o, 1);
    strobe();
    chk("t4_muted_hold", drive_o, 0);
    mute_i = 1'b0;
    tick();
    chk("t4_unmute_state", state_o, S_RAMP);
    for (int i = 0; i < 4; i++) begin
      strobe();
      chk("t4_climb", drive_o, 32'((i + 1) * 16'h0100));
    end
    chk("t4_end_state", state_o, S_IDLE);

    // Retarget colliding with a strobe
    cfg(16'h0200, 15'h0000);
    strobe();
    cfg(16'h0400, 15'h0100);
    cfg_we_i    = 1'b1;
    cfg_drive_i = 16'h0000;
    cfg_step_i  = 15'h0100;
    smp_stb_i   = 1'b1;
    tick();
    cfg_we_i  = 1'b0;
    smp_stb_i = 1'b0;
    chk("t5_collide", drive_o, 16'h0300);
    chk("t5_ack", cfg_ack_o, 1);
    exp_a = '{16'h0200, 16'h0100, 16'h0000, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      strobe();
      chk("t5_down", drive_o, exp_a[i]);
    end
    chk("t5_done", done_o, 1);
    chk("t5_state", state_o, S_IDLE);

    // Asynchronous reset mid-ramp
    cfg(16'h0400, 15'h0100);
    strobe();
    strobe();
    strobe();
    chk("t6_pre", drive_o, 16'h0300);
    chk("t6_pre_busy", busy_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_drive", drive_o, 0);
    chk("t6_rst_state", state_o, S_IDLE);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_done", done_o, 0);
    chk("t6_rst_ack", cfg_ack_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    strobe();
    strobe();
    chk("t6_post_drive", drive_o, 0);
    chk("t6_post_state", state_o, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
